rps_datapath: RTL and testbench

RPS_DATAPATH -- requirements
Module: rps_datapath

---
 rtl/rps_pkg.sv | 35 +++
 rtl/rps_datapath_key_debounce.sv | 54 +++++
 rtl/rps_datapath.sv | 136 +++++++++++++
 tb/tb_rps_datapath.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared symbol/outcome encodings, timing defaults and the rock-paper-scissors helpers.
package rps_pkg;

  typedef logic [1:0] sym_t;
  typedef logic [1:0] res_t;

  localparam sym_t SYM_ROCK     = 2'b00;
  localparam sym_t SYM_PAPER    = 2'b01;
  localparam sym_t SYM_SCISSORS = 2'b10;
  localparam sym_t SYM_INVALID  = 2'b11;

  localparam res_t RES_TIE  = 2'b00;
  localparam res_t RES_WIN  = 2'b01;
  localparam res_t RES_LOSE = 2'b10;

  localparam int TICK_DIV_DEF     = 2500000;
  localparam int DEBOUNCE_CYC_DEF = 500000;

  function automatic sym_t sym_next(input sym_t s);
    return (s == SYM_SCISSORS) ? SYM_ROCK : sym_t'(s + 2'b01);
  endfunction

  // Outcome from the user's point of view against one reel.
  function automatic res_t rps_beat(input sym_t usr, input sym_t oth);
    if (usr == oth)
      return RES_TIE;
    else if ((usr == SYM_PAPER    && oth == SYM_ROCK)  ||
             (usr == SYM_SCISSORS && oth == SYM_PAPER) ||
             (usr == SYM_ROCK     && oth == SYM_SCISSORS))
      return RES_WIN;
    else
      return RES_LOSE;
  endfunction

endpackage

// File: rtl/rps_datapath_key_debounce.sv
// Stop-key 2-flop synchronizer plus debouncer; press pulses in the same cycle key_db falls.
module key_debounce #(
  parameter int DEBOUNCE_CYC = rps_pkg::DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic key_db,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q tracks how many consecutive samples have disagreed with the debounced level.
  always_comb begin
    cnt_d   = '0;
    db_d    = db_q;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d    = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_db = db_q;
  assign press  = press_q;

endmodule

// File: rtl/rps_datapath.sv
// Two spinning reels plus a user choice, each captured by a debounced stop key,
// with registered win/tie/lose outcomes one cycle after the user capture.
module rps_datapath
  import rps_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ld_left,
  input  logic       ld_right,
  input  logic       ld_user,
  input  logic       key_stop_n,
  input  logic [1:0] user_sel,
  output logic       stop_left,
  output logic       stop_right,
  output logic       stop_rps,
  output logic [1:0] left_sym,
  output logic [1:0] right_sym,
  output logic [1:0] user_sym,
  output logic [1:0] res_left,
  output logic [1:0] res_right,
  output logic       res_valid
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic key_db, press;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_debounce (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (key_stop_n),
    .key_db (key_db),
    .press  (press)
  );

  logic [TW-1:0] tick_q, tick_d;
  sym_t          left_q, left_d, right_q, right_d, user_q, user_d;
  res_t          res_l_q, res_l_d, res_r_q, res_r_d;
  logic          vld_q, vld_d, ucap_q, ucap_d;
  logic          lcap_q, lcap_d, rcap_q, rcap_d;
  logic          stl_q, stl_d, str_q, str_d, stu_q, stu_d;
  logic          ldl_q, ldr_q;

  logic act_l, act_r, act_u, spin, wrap, rise_l, rise_r;
  logic cap_l, cap_r, cap_u, frz_l, frz_r;

  always_comb begin
    act_l  = ld_left;
    act_r  = ~ld_left & ld_right;
    act_u  = ~ld_left & ~ld_right & ld_user;
    spin   = ld_left | ld_right;
    wrap   = spin && (tick_q == TICK_MAX);
    rise_l = ld_left & ~ldl_q;
    rise_r = ld_right & ~ldr_q;
    cap_l  = press & act_l;
    cap_r  = press & act_r;
    cap_u  = press & act_u & (user_sel != SYM_INVALID);
    // A reel stays frozen after capture until its ld rises again.
    frz_l  = lcap_q & ~rise_l;
    frz_r  = rcap_q & ~rise_r;

    tick_d  = (spin && !wrap) ? tick_q + 1'b1 : '0;
    left_d  = (wrap && act_l && !cap_l && !frz_l) ? sym_next(left_q) : left_q;
    right_d = (wrap && act_r && !cap_r && !frz_r) ? sym_next(right_q) : right_q;
    lcap_d  = cap_l | frz_l;
    rcap_d  = cap_r | frz_r;
    user_d  = cap_u ? user_sel : user_q;
    ucap_d  = cap_u;

    stl_d = key_db ? 1'b1 : (cap_l ? 1'b0 : stl_q);
    str_d = key_db ? 1'b1 : (cap_r ? 1'b0 : str_q);
    stu_d = key_db ? 1'b1 : (cap_u ? 1'b0 : stu_q);

    res_l_d = res_l_q;
    res_r_d = res_r_q;
    vld_d   = vld_q;
    if (ucap_q) begin
      res_l_d = rps_beat(user_q, left_q);
      res_r_d = rps_beat(user_q, right_q);
      vld_d   = 1'b1;
    end else if (rise_l) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_q  <= '0;
      left_q  <= SYM_ROCK;
      right_q <= SYM_ROCK;
      user_q  <= SYM_ROCK;
      res_l_q <= RES_TIE;
      res_r_q <= RES_TIE;
      vld_q   <= 1'b0;
      ucap_q  <= 1'b0;
      lcap_q  <= 1'b0;
      rcap_q  <= 1'b0;
      stl_q   <= 1'b1;
      str_q   <= 1'b1;
      stu_q   <= 1'b1;
      ldl_q   <= 1'b0;
      ldr_q   <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      left_q  <= left_d;
      right_q <= right_d;
      user_q  <= user_d;
      res_l_q <= res_l_d;
      res_r_q <= res_r_d;
      vld_q   <= vld_d;
      ucap_q  <= ucap_d;
      lcap_q  <= lcap_d;
      rcap_q  <= rcap_d;
      stl_q   <= stl_d;
      str_q   <= str_d;
      stu_q   <= stu_d;
      ldl_q   <= ld_left;
      ldr_q   <= ld_right;
    end
  end

  assign stop_left  = stl_q;
  assign stop_right = str_q;
  assign stop_rps   = stu_q;
  assign left_sym   = left_q;
  assign right_sym  = right_q;
  assign user_sym   = user_q;
  assign res_left   = res_l_q;
  assign res_right  = res_r_q;
  assign res_valid  = vld_q;

endmodule

// File: tb/tb_rps_datapath.sv
// Directed bench for rps_datapath with TICK_DIV=4, DEBOUNCE_CYC=8.
module tb_rps_datapath;

  logic       clk = 1'b0;
  logic       resetn, ld_left, ld_right, ld_user, key_stop_n;
  logic [1:0] user_sel;
  logic       stop_left, stop_right, stop_rps, res_valid;
  logic [1:0] left_sym, right_sym, user_sym, res_left, res_right;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rps_datapath #(.TICK_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ld_left    (ld_left),
    .ld_right   (ld_right),
    .ld_user    (ld_user),
    .key_stop_n (key_stop_n),
    .user_sel   (user_sel),
    .stop_left  (stop_left),
    .stop_right (stop_right),
    .stop_rps   (stop_rps),
    .left_sym   (left_sym),
    .right_sym  (right_sym),
    .user_sym   (user_sym),
    .res_left   (res_left),
    .res_right  (res_right),
    .res_valid  (res_valid)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetn = 1'b0; ld_left = 1'b0; ld_right = 1'b0; ld_user = 1'b0;
    key_stop_n = 1'b1; user_sel = 2'b00;
    tick(2);
    resetn = 1'b1;
    chk("rst_left", 8'(left_sym), 8'h0);
    chk("rst_right", 8'(right_sym), 8'h0);
    chk("rst_user", 8'(user_sym), 8'h0);
    chk("rst_res", 8'({res_left, res_right}), 8'h0);
    chk("rst_valid", 8'(res_valid), 8'h0);
    chk("rst_stops", 8'({stop_left, stop_right, stop_rps}), 8'h7);

    // Left reel spins: one step every 4 cycles.
    ld_left = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      chk("spin_left", 8'(left_sym), 8'((i / 4) % 3));
    end
    chk("spin_right", 8'(right_sym), 8'h0);

    // Held key: press after sync+debounce, stop_left low, reel frozen.
    key_stop_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      chk("press_stop", 8'(stop_left), (i >= 11) ? 8'h0 : 8'h1);
      chk("press_left", 8'(left_sym), (i < 4) ? 8'h0 : ((i < 8) ? 8'h1 : 8'h2));
    end
    key_stop_n = 1'b1;
    for (int i = 21; i <= 32; i++) begin
      tick(1);
      chk("rel_stop", 8'(stop_left), (i >= 31) ? 8'h1 : 8'h0);
      chk("rel_left", 8'(left_sym), 8'h2);
    end
    chk("rel_others", 8'({stop_right, stop_rps}), 8'h3);

    // Bouncing key never settles long enough for a press.
    for (int i = 0; i < 30; i++) begin
      key_stop_n = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
      tick(1);
      chk("bounce_stops", 8'({stop_left, stop_right, stop_rps}), 8'h7);
    end
    key_stop_n = 1'b1;
    tick(12);
    chk("bounce_left", 8'(left_sym), 8'h2);

    // User paper vs left scissors / right rock.
    ld_left = 1'b0; ld_user = 1'b1; user_sel = 2'b01; key_stop_n = 1'b0;
    tick(10);
    chk("u_pre_stop", 8'(stop_rps), 8'h1);
    chk("u_pre_valid", 8'(res_valid), 8'h0);
    tick(1);
    chk("u_cap_sym", 8'(user_sym), 8'h1);
    chk("u_cap_stop", 8'(stop_rps), 8'h0);
    chk("u_cap_valid", 8'(res_valid), 8'h0);
    tick(1);
    chk("u_res_valid", 8'(res_valid), 8'h1);
    chk("u_res_left", 8'(res_left), 8'h2);
    chk("u_res_right", 8'(res_right), 8'h1);
    key_stop_n = 1'b1;
    tick(12);
    chk("u_rel_stop", 8'(stop_rps), 8'h1);
    chk("u_hold_valid", 8'(res_valid), 8'h1);
    ld_user = 1'b0; ld_left = 1'b1;
    tick(1);
    chk("rise_valid", 8'(res_valid), 8'h0);
    chk("rise_res_left", 8'(res_left), 8'h2);
    chk("rise_left", 8'(left_sym), 8'h2);
    tick(3);
    chk("resume_left", 8'(left_sym), 8'h0);

    // Invalid user choice: press ignored.
    ld_left = 1'b0; ld_user = 1'b1; user_sel = 2'b11; key_stop_n = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick(1);
      chk("inv_stop", 8'(stop_rps), 8'h1);
    end
    chk("inv_user", 8'(user_sym), 8'h1);
    chk("inv_valid", 8'(res_valid), 8'h0);
    key_stop_n = 1'b1;
    tick(12);

    // Reset during a right-reel press; held key presses again afterwards.
    ld_user = 1'b0; ld_right = 1'b1; key_stop_n = 1'b0;
    tick(11);
    chk("r_cap_stop", 8'(stop_right), 8'h0);
    chk("r_cap_sym", 8'(right_sym), 8'h2);
    chk("r_cap_left", 8'(stop_left), 8'h1);
    resetn = 1'b0;
    tick(1);
    chk("r_rst_stop", 8'(stop_right), 8'h1);
    chk("r_rst_sym", 8'(right_sym), 8'h0);
    chk("r_rst_user", 8'(user_sym), 8'h0);
    chk("r_rst_valid", 8'(res_valid), 8'h0);
    resetn = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick(1);
      chk("r_again_stop", 8'(stop_right), (i == 11) ? 8'h0 : 8'h1);
    end
    chk("r_again_sym", 8'(right_sym), 8'h2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
